// File: rtl/arp_nexthop_rewrite.sv
`default_nettype none
// ============================================================================
// arp_nexthop_rewrite : ARP next-hop resolution, dst MAC / dst port rewrite
// Optional macro ARP_TTL_REWRITE_EN : TTL decrement + checksum fix-up on hits
// Rev 1.0
// ============================================================================
module arp_nexthop_rewrite #(
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS         = 16,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                                AXI_ACLK,
  input  logic                                AXI_RESETN,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
  input  logic                                S_AXIS_TVALID,
  input  logic                                S_AXIS_TLAST,
  output logic                                S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                                M_AXIS_TVALID,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY,
  input  logic                                lpm_hit,
  input  logic [31:0]                         nh_ip,
  input  logic [31:0]                         oq,
  input  logic                                tbl_rd_req,
  input  logic                                tbl_wr_req,
  input  logic [4:0]                          tbl_rd_addr,
  input  logic [4:0]                          tbl_wr_addr,
  input  logic [4*C_S_AXI_DATA_WIDTH-1:0]     tbl_wr_data,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]     tbl_rd_data,
  output logic                                tbl_rd_ack,
  output logic                                tbl_wr_ack,
  input  logic                                miss_cnt_clr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       arp_miss_count
);

  localparam int DW      = C_S_AXIS_DATA_WIDTH;
  localparam int SW      = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW      = C_S_AXIS_TUSER_WIDTH;
  localparam int EW      = 4 * C_S_AXI_DATA_WIDTH;
  localparam int FIFO_W  = 1 + UW + SW + DW;
  localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE = 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_HDR    = 2'd2;
  localparam logic [1:0] S_BODY   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [FIFO_W-1:0] mem_q [4];
  logic [FIFO_W-1:0] mem_d [4];
  logic [1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]        count_q, count_d;
  logic [EW-1:0]     tbl_q [32];
  logic [EW-1:0]     tbl_d [32];
  logic [EW-1:0]     rd_data_q, rd_data_d;
  logic              rd_ack_q, wr_ack_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic              rw_q, rw_d, mac_en_q, mac_en_d, miss_q, miss_d;
  logic [7:0]        dst_q, dst_d;
  logic [47:0]       mac_q, mac_d;

  logic              fifo_wr, fifo_rd, fifo_empty, m_valid, miss_evt;
  logic              lk_hit, ttl_ok;
  logic [47:0]       lk_mac;
  logic [7:0]        src_cpu;
  logic [FIFO_W-1:0] head;
  logic [DW-1:0]     h_data, out_data;
  logic [SW-1:0]     h_strb;
  logic [UW-1:0]     h_user, out_user;
  logic              h_last;

  // Fall-through FIFO: the head word is visible combinationally.
  assign S_AXIS_TREADY = (count_q < 3'd3);
  assign fifo_wr       = S_AXIS_TVALID && S_AXIS_TREADY;
  assign fifo_empty    = (count_q == 3'd0);
  assign head          = mem_q[rd_ptr_q];
  assign h_data        = head[DW-1:0];
  assign h_strb        = head[DW +: SW];
  assign h_user        = head[DW+SW +: UW];
  assign h_last        = head[FIFO_W-1];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_wr) begin
      mem_d[wr_ptr_q] = {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
      wr_ptr_d        = wr_ptr_q + 2'd1;
    end
    if (fifo_rd) rd_ptr_d = rd_ptr_q + 2'd1;
    count_d = count_q + {2'b00, fifo_wr} - {2'b00, fifo_rd};
  end

  always_comb begin
    tbl_d = tbl_q;
    if (tbl_wr_req) tbl_d[tbl_wr_addr] = tbl_wr_data;
    rd_data_d = tbl_rd_req ? tbl_q[tbl_rd_addr] : rd_data_q;
  end

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    lk_hit = 1'b0;
    lk_mac = '0;
    for (int i = 31; i >= 0; i--) begin
      if (tbl_q[i][EW-1] && (tbl_q[i][31:0] == nh_ip)) begin
        lk_hit = 1'b1;
        lk_mac = tbl_q[i][79:32];
      end
    end
  end

`ifdef ARP_TTL_REWRITE_EN
  assign ttl_ok = (h_data[79:72] > 8'd1);
`else
  assign ttl_ok = 1'b1;
`endif

  assign src_cpu = {h_user[SRC_PORT_POS +: 7], 1'b0};

  always_comb begin
    rw_d     = rw_q;
    miss_d   = miss_q;
    mac_en_d = mac_en_q;
    mac_d    = mac_q;
    dst_d    = dst_q;
    if (state_q == S_IDLE && !fifo_empty) begin
      rw_d     = lpm_hit && (h_user[DST_PORT_POS +: 8] == 8'd0);
      miss_d   = rw_d && !lk_hit;
      mac_en_d = rw_d && lk_hit && (oq < 32'd4) && ttl_ok;
      mac_d    = lk_mac;
      dst_d    = mac_en_d ? (8'd1 << {oq[1:0], 1'b0}) : src_cpu;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!fifo_empty) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_HDR;
      S_HDR:    if (fifo_rd) state_d = h_last ? S_IDLE : S_BODY;
      S_BODY:   if (fifo_rd && h_last) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

`ifdef ARP_TTL_REWRITE_EN
  logic [16:0] cks_sum;
`endif

  always_comb begin
    m_valid  = 1'b0;
    out_data = h_data;
    out_user = h_user;
`ifdef ARP_TTL_REWRITE_EN
    cks_sum  = '0;
`endif
    case (state_q)
      S_HDR: begin
        m_valid = 1'b1;
        if (rw_q) out_user[DST_PORT_POS +: 8] = dst_q;
        if (mac_en_q) begin
          out_data[DW-1 -: 48] = mac_q;
`ifdef ARP_TTL_REWRITE_EN
          // One's-complement add of 0x0100 compensates the TTL decrement.
          out_data[79:72] = h_data[79:72] - 8'd1;
          cks_sum         = {1'b0, h_data[63:48]} + 17'h00100;
          out_data[63:48] = cks_sum[15:0] + {15'd0, cks_sum[16]};
`endif
        end
      end
      S_BODY:  m_valid = !fifo_empty;
      default: m_valid = 1'b0;
    endcase
  end

  assign fifo_rd  = m_valid && M_AXIS_TREADY;
  assign miss_evt = (state_q == S_HDR) && fifo_rd && miss_q;

  always_comb begin
    cnt_d = cnt_q;
    if (miss_cnt_clr)  cnt_d = '0;
    else if (miss_evt) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_ff @(posedge AXI_ACLK) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_RESETN) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tbl_q     <= '{default: '0};
      rd_data_q <= '0;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      miss_q    <= 1'b0;
      mac_en_q  <= 1'b0;
      mac_q     <= '0;
      dst_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tbl_q     <= tbl_d;
      rd_data_q <= rd_data_d;
      rd_ack_q  <= tbl_rd_req;
      wr_ack_q  <= tbl_wr_req;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      miss_q    <= miss_d;
      mac_en_q  <= mac_en_d;
      mac_q     <= mac_d;
      dst_q     <= dst_d;
    end
  end

  assign M_AXIS_TVALID  = m_valid;
  assign M_AXIS_TDATA   = m_valid ? out_data : '0;
  assign M_AXIS_TSTRB   = m_valid ? h_strb   : '0;
  assign M_AXIS_TUSER   = m_valid ? out_user : '0;
  assign M_AXIS_TLAST   = m_valid && h_last;
  assign tbl_rd_data    = rd_data_q;
  assign tbl_rd_ack     = rd_ack_q;
  assign tbl_wr_ack     = wr_ack_q;
  assign arp_miss_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_arp_nexthop_rewrite.sv
`default_nettype none
// tb_arp_nexthop_rewrite : scoreboard bench with a behavioural ARP/rewrite reference model.
module tb_arp_nexthop_rewrite;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [255:0] s_tdata;
  logic [31:0]  s_tstrb;
  logic [127:0] s_tuser;
  logic         s_tvalid, s_tlast, s_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid, m_tlast, m_tready;
  logic         lpm_hit;
  logic [31:0]  nh_ip, oq;
  logic         tbl_rd_req, tbl_wr_req, tbl_rd_ack, tbl_wr_ack;
  logic [4:0]   tbl_rd_addr, tbl_wr_addr;
  logic [127:0] tbl_wr_data, tbl_rd_data;
  logic         miss_cnt_clr;
  logic [31:0]  arp_miss_count;

  arp_nexthop_rewrite dut (
    .AXI_ACLK(clk), .AXI_RESETN(rstn),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TUSER(s_tuser),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TLAST(s_tlast), .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TUSER(m_tuser),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TLAST(m_tlast), .M_AXIS_TREADY(m_tready),
    .lpm_hit(lpm_hit), .nh_ip(nh_ip), .oq(oq),
    .tbl_rd_req(tbl_rd_req), .tbl_wr_req(tbl_wr_req),
    .tbl_rd_addr(tbl_rd_addr), .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_data(tbl_wr_data), .tbl_rd_data(tbl_rd_data),
    .tbl_rd_ack(tbl_rd_ack), .tbl_wr_ack(tbl_wr_ack),
    .miss_cnt_clr(miss_cnt_clr), .arp_miss_count(arp_miss_count)
  );

  typedef struct {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        mon_e;
  logic [127:0] mtbl [32];
  int           model_cnt = 0;
  int           n_checks  = 0;
  int           n_fail    = 0;
  bit           rand_ready = 1'b0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [127:0] mk_entry(input bit v, input logic [47:0] mac, input logic [31:0] ip);
    return {v, 47'h0, mac, ip};
  endfunction

  // Reference behaviour of a first beat, from the table image kept in mtbl.
  function automatic void model_first(input logic hit, input logic [31:0] ip, input logic [31:0] q,
                                      inout beat_t b, output bit miss);
    int idx;
    bit ttl_ok;
    logic [7:0] cpu;
    miss = 1'b0;
    if (!hit || b.u[31:24] != 8'h00) return;
    idx = -1;
    for (int i = 0; i < 32; i++)
      if (idx < 0 && mtbl[i][127] && mtbl[i][31:0] == ip) idx = i;
    cpu = b.u[23:16] << 1;
    ttl_ok = 1'b1;
`ifdef ARP_TTL_REWRITE_EN
    ttl_ok = (b.d[79:72] > 8'd1);
`endif
    if (idx < 0) begin
      b.u[31:24] = cpu;
      miss = 1'b1;
    end else if (q < 4 && ttl_ok) begin
      b.d[255:208] = mtbl[idx][79:32];
      b.u[31:24]   = 8'(1 << (2 * q));
`ifdef ARP_TTL_REWRITE_EN
      begin
        int s;
        b.d[79:72] = b.d[79:72] - 8'd1;
        s = int'(b.d[63:48]) + 256;
        if (s > 65535) s = s - 65535;
        b.d[63:48] = s[15:0];
      end
`endif
    end else begin
      b.u[31:24] = cpu;
    end
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tbl_write(input int a, input logic [127:0] v);
    tbl_wr_req = 1'b1; tbl_wr_addr = a[4:0]; tbl_wr_data = v;
    cyc(1);
    tbl_wr_req = 1'b0;
    mtbl[a] = v;
    check("tbl_wr_ack", tbl_wr_ack, 1);
  endtask

  task automatic tbl_read(input int a, input string nm);
    tbl_rd_req = 1'b1; tbl_rd_addr = a[4:0];
    cyc(1);
    tbl_rd_req = 1'b0;
    check({nm, "_ack"}, tbl_rd_ack, 1);
    check({nm, "_data"}, tbl_rd_data, mtbl[a]);
  endtask

  task automatic send_pkt(input logic hit, input logic [31:0] ip, input logic [31:0] q,
                          input logic [7:0] src, input logic [7:0] dst, input int nb,
                          input logic [7:0] ttl, input logic [15:0] cks, input int gap);
    beat_t b;
    bit miss;
    int t;
    lpm_hit = hit; nh_ip = ip; oq = q;
    for (int k = 0; k < nb; k++) begin
      if (gap > 0) cyc($urandom_range(0, gap));
      b.d = rand256();
      b.s = $urandom();
      b.u = {$urandom(), $urandom(), $urandom(), $urandom()};
      b.l = (k == nb - 1);
      if (k == 0) begin
        b.u[23:16] = src; b.u[31:24] = dst;
        b.d[79:72] = ttl; b.d[63:48] = cks;
      end
      s_tdata = b.d; s_tstrb = b.s; s_tuser = b.u; s_tlast = b.l; s_tvalid = 1'b1;
      if (k == 0) begin
        model_first(hit, ip, q, b, miss);
        if (miss) model_cnt++;
      end
      exp_q.push_back(b);
      t = 0;
      while (!s_tready && t < 500) begin
        cyc(1);
        t++;
      end
      check("s_tready_wait", s_tready, 1);
      cyc(1);
      s_tvalid = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      cyc(1);
      t++;
    end
    check({nm, "_drained"}, exp_q.size(), 0);
    cyc(3);
    check({nm, "_miss_cnt"}, arp_miss_count, model_cnt);
  endtask

  task automatic wait_valid(input string nm);
    int t;
    t = 0;
    while (!m_tvalid && t < 100) begin
      cyc(1);
      t++;
    end
    check({nm, "_valid"}, m_tvalid, 1);
  endtask

  always @(negedge clk) begin
    if (rstn && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got data %0h expected no beat", m_tdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_tdata", m_tdata, mon_e.d);
        check("out_tstrb", m_tstrb, mon_e.s);
        check("out_tuser", m_tuser, mon_e.u);
        check("out_tlast", m_tlast, mon_e.l);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_tready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [127:0] oldv, newv;
    s_tdata = '0; s_tstrb = '0; s_tuser = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    m_tready = 1'b1; lpm_hit = 1'b0; nh_ip = '0; oq = '0;
    tbl_rd_req = 1'b0; tbl_wr_req = 1'b0; tbl_rd_addr = '0; tbl_wr_addr = '0; tbl_wr_data = '0;
    miss_cnt_clr = 1'b0;
    for (int i = 0; i < 32; i++) mtbl[i] = '0;

    cyc(4);
    rstn = 1'b1;
    cyc(1);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_s_tready", s_tready, 1);
    check("rst_miss_cnt", arp_miss_count, 0);
    check("rst_rd_ack", tbl_rd_ack, 0);
    tbl_read(7, "rst_tbl7");
    check("wr_ack_idle", tbl_wr_ack, 0);

    // Same-cycle read and write of one address returns the old contents.
    tbl_write(3, mk_entry(1, 48'h111111111111, 32'h0A0000AA));
    oldv = mtbl[3];
    newv = mk_entry(0, 48'h222222222222, 32'h0A0000BB);
    tbl_rd_req = 1'b1; tbl_rd_addr = 5'd3;
    tbl_wr_req = 1'b1; tbl_wr_addr = 5'd3; tbl_wr_data = newv;
    cyc(1);
    tbl_rd_req = 1'b0; tbl_wr_req = 1'b0;
    check("rdwr_old", tbl_rd_data, oldv);
    check("wr_ack_pulse", tbl_wr_ack, 1);
    mtbl[3] = newv;
    cyc(1);
    check("wr_ack_drop", tbl_wr_ack, 0);
    tbl_read(3, "rdwr_new");

    // ARP hit, oq=2.
    tbl_write(3, mk_entry(1, 48'h0A0B0C0D0E0F, 32'h0A000002));
    send_pkt(1, 32'h0A000002, 2, 8'h01, 8'h00, 1, 8'h40, 16'h1234, 0);
    drain("hit_oq2");
    // ARP miss.
    send_pkt(1, 32'h0A000009, 2, 8'h04, 8'h00, 2, 8'h40, 16'h1234, 1);
    drain("miss");
    check("miss_cnt_one", arp_miss_count, 1);
    // Duplicate IPs: lowest index wins.
    tbl_write(3, '0);
    tbl_write(9, mk_entry(1, 48'h999999999999, 32'h0A000002));
    tbl_write(5, mk_entry(1, 48'h555555555555, 32'h0A000002));
    send_pkt(1, 32'h0A000002, 0, 8'h10, 8'h00, 3, 8'h40, 16'h0000, 1);
    drain("dup");
    // oq beyond physical ports, pass-through cases.
    send_pkt(1, 32'h0A000002, 5, 8'h40, 8'h00, 1, 8'h40, 16'h0, 0);
    drain("oq_cpu");
    send_pkt(0, 32'h0A000002, 1, 8'h01, 8'h00, 2, 8'h40, 16'h0, 0);
    drain("nohit");
    send_pkt(1, 32'h0A000009, 1, 8'h01, 8'h20, 2, 8'h40, 16'h0, 0);
    drain("dst_set");
`ifdef ARP_TTL_REWRITE_EN
    send_pkt(1, 32'h0A000002, 1, 8'h01, 8'h00, 1, 8'h40, 16'hFFFF, 0);
    drain("ttl_dec");
    send_pkt(1, 32'h0A000002, 1, 8'h04, 8'h00, 1, 8'h01, 16'h1111, 0);
    drain("ttl_expire");
`endif

    // First beat at FIFO head shows on the output two cycles later.
    send_pkt(0, 32'h0, 0, 8'h01, 8'h00, 1, 8'h40, 16'h0, 0);
    lat = 0;
    while (!m_tvalid && lat < 10) begin
      cyc(1);
      lat++;
    end
    check("latency", lat, 2);
    drain("latency");

    // Back-pressure on the first beat of a 3-beat miss packet.
    m_tready = 1'b0;
    send_pkt(1, 32'h0A000077, 0, 8'h01, 8'h00, 3, 8'h40, 16'h0, 0);
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid", m_tvalid, 1);
      check("bp_hold_tdata", m_tdata, exp_q[0].d);
      check("bp_hold_tuser", m_tuser, exp_q[0].u);
      cyc(1);
    end
    m_tready = 1'b1;
    drain("bp");

    // Counter clear on the same edge as a miss handshake.
    m_tready = 1'b0;
    send_pkt(1, 32'h0A000078, 3, 8'h40, 8'h00, 1, 8'h40, 16'h0, 0);
    wait_valid("clr");
    m_tready = 1'b1; miss_cnt_clr = 1'b1;
    cyc(1);
    miss_cnt_clr = 1'b0;
    model_cnt = 0;
    check("clr_priority", arp_miss_count, 0);
    drain("clr");

    // Randomized traffic against a random table.
    for (int i = 0; i < 32; i++)
      if ($urandom_range(0, 2) == 0)
        tbl_write(i, {$urandom_range(0, 1) == 1, 47'($urandom()),
                      {16'($urandom()), 32'($urandom())}, 32'h0A000001 + 32'($urandom_range(0, 7))});
    tbl_write(0, mk_entry(1, 48'hCAFE0000BEEF, 32'h0A000004));
    rand_ready = 1'b1;
    for (int p = 0; p < 60; p++) begin
      send_pkt($urandom_range(0, 4) != 0, 32'h0A000001 + 32'($urandom_range(0, 9)),
               32'($urandom_range(0, 6)), 8'h01 << (2 * $urandom_range(0, 3)),
               ($urandom_range(0, 5) == 0) ? 8'h02 : 8'h00, $urandom_range(1, 4),
               ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom()),
               16'($urandom()), 2);
      drain("rand");
    end
    rand_ready = 1'b0;
    m_tready = 1'b1;
    cyc(2);

    // Reset in the middle of a held packet.
    tbl_write(3, mk_entry(1, 48'h0A0B0C0D0E0F, 32'h0A000002));
    m_tready = 1'b0;
    send_pkt(1, 32'h0A000002, 1, 8'h01, 8'h00, 3, 8'h40, 16'h0, 0);
    wait_valid("mid_rst");
    rstn = 1'b0;
    cyc(2);
    exp_q.delete();
    for (int i = 0; i < 32; i++) mtbl[i] = '0;
    model_cnt = 0;
    rstn = 1'b1;
    m_tready = 1'b1;
    cyc(1);
    check("mid_rst_m_tvalid", m_tvalid, 0);
    check("mid_rst_s_tready", s_tready, 1);
    check("mid_rst_cnt", arp_miss_count, 0);
    tbl_read(3, "mid_rst_tbl3");
    cyc(3);
    check("mid_rst_idle", m_tvalid, 0);
    send_pkt(1, 32'h0A000002, 1, 8'h04, 8'h00, 2, 8'h40, 16'h0, 0);
    drain("post_rst");
    check("post_rst_cnt", arp_miss_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arp_nexthop_rewrite.md
Name: arp_nexthop_rewrite

Overview:
- Stage directly downstream of the LPM lookup stage in the router output-port-lookup pipeline.
- Consumes the packet stream plus the LPM sideband (hit, next-hop IP, output queue index).
- Resolves the next-hop IP to a MAC through a 32-entry software-programmed ARP table, rewrites the Ethernet destination MAC, and sets the one-hot destination port in TUSER.
- On an ARP miss it redirects the packet to the CPU queue paired with its source port and counts the miss.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, register/table word base width; table entry is 4x this.
- C_M_AXIS_DATA_WIDTH, 256, output stream data width.
- C_S_AXIS_DATA_WIDTH, 256, input stream data width.
- C_M_AXIS_TUSER_WIDTH, 128, output TUSER width.
- C_S_AXIS_TUSER_WIDTH, 128, input TUSER width.
- SRC_PORT_POS, 16, LSB of the source-port one-hot byte in TUSER.
- DST_PORT_POS, 24, LSB of the destination-port one-hot byte in TUSER.

Ports:
- AXI_ACLK  in  1  clock.
- AXI_RESETN  in  1  synchronous active-low reset.
- S_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  in  256/32/128/1/1  packet from the LPM stage.
- S_AXIS_TREADY  out  1  input ready.
- M_AXIS_TDATA/TSTRB/TUSER/TVALID/TLAST  out  256/32/128/1/1  rewritten packet.
- M_AXIS_TREADY  in  1  output ready.
- lpm_hit  in  1  LPM matched.
- nh_ip  in  32  next-hop IP.
- oq  in  32  output queue index.
- tbl_rd_req, tbl_wr_req  in  1  table access strobes.
- tbl_rd_addr, tbl_wr_addr  in  5  table index.
- tbl_wr_data  in  128  entry to write.
- tbl_rd_data  out  128  entry read.
- tbl_rd_ack, tbl_wr_ack  out  1  one-cycle ack.
- miss_cnt_clr  in  1  clear miss counter.
- arp_miss_count  out  32  ARP miss counter.

Behaviour:
- Clock and reset: one clock, AXI_ACLK. Reset is synchronous, active-low, on AXI_RESETN.
- Reset values:
  - All outputs 0, except M_AXIS_TVALID=0 and S_AXIS_TREADY=1 once the FIFO has left reset.
  - Input FIFO flushed; state = IDLE.
  - All table entries = 0, so every entry is invalid.
- Table entry layout: [31:0] IP, [79:32] MAC, [127] valid, other bits reserved (stored, ignored).
- Table access:
  - A write lands at the clock edge where tbl_wr_req=1; tbl_wr_ack is high for the next cycle only.
  - A read registers tbl_rd_data and tbl_rd_ack one cycle after tbl_rd_req.
  - A read and a write may occur in the same cycle. A read of the address being written returns the old value.
- Input buffering: 4-deep fall-through FIFO holding {TLAST, TUSER, TSTRB, TDATA}. S_AXIS_TREADY = !nearly_full.
- Sideband contract: upstream holds lpm_hit, nh_ip and oq stable from first-beat presentation through TLAST. The sideband is sampled when the first beat reaches the FIFO head.
- FSM states:
  - IDLE: on FIFO non-empty, register the lookup result (hit_r, mac_r, miss_r), then go to LOOKUP. M_AXIS_TVALID=0 in IDLE.
  - LOOKUP: one cycle, M_AXIS_TVALID=0; then go to HDR.
  - HDR: present the rewritten first beat. On handshake go to BODY, or to IDLE if TLAST.
  - BODY: pass-through. On a handshake with TLAST go to IDLE.
- Lookup:
  - Compare nh_ip against all valid entries; the lowest matching index wins.
  - The lookup uses table contents as of the IDLE cycle. A write in that same cycle is not seen.
- First-beat rewrite, applied only when lpm_hit=1 and the TUSER dst byte is 0:
  - ARP hit, oq in 0..3: TDATA[255:208] = entry MAC; TUSER dst byte = 8'b1 << (2*oq).
  - ARP hit, oq >= 4: TUSER dst byte = CPU port of source (see miss rule); MAC untouched.
  - ARP miss: TUSER dst byte = source one-hot shifted left by 1 (SRC bit 2k maps to DST bit 2k+1). arp_miss_count += 1 once per packet, on the HDR handshake.
- Pass-through cases: lpm_hit=0 or a nonzero dst byte means the beat passes unmodified and nothing is counted.
- Latency: a first beat at the FIFO head appears on M_AXIS 2 cycles later. Later beats are zero-latency fall-through.
- Counter: arp_miss_count wraps at 2^32. miss_cnt_clr forces 0 and has priority over a same-cycle increment.
- Back-pressure: M_AXIS_TREADY low holds the beat and its rewrite stable; the lookup is not repeated.
- Single-beat packets (TLAST on the first beat) follow IDLE, LOOKUP, HDR, IDLE.

Optional Feature:
- Macro: ARP_TTL_REWRITE_EN.
- Defined: on the rewritten first beat (ARP hit, oq 0..3), TDATA[79:72] (TTL) -= 1 and TDATA[63:48] (checksum) += 16'h0100 with end-around carry.
  - If TTL is 0 or 1, there is no rewrite and the packet goes to the source CPU port as a miss; it is not counted as an ARP miss.
- Undefined: TTL and checksum pass unmodified.

Test Plan:
- Write entry 3 = {valid, MAC 0x0A0B0C0D0E0F, IP 10.0.0.2}; packet with lpm_hit=1, nh_ip=10.0.0.2, oq=2, TUSER src=0x01 -> out TDATA[255:208]=0x0A0B0C0D0E0F, dst byte=0x10, miss count 0.
- Same packet, nh_ip=10.0.0.9 (no entry), src=0x04 -> dst byte=0x08, MAC unchanged, arp_miss_count=1.
- Entries 5 and 9 both hold IP 10.0.0.2 with different MACs -> MAC from entry 5.
- Hold M_AXIS_TREADY=0 for 10 cycles on the first beat of a 3-beat packet -> beats held stable, exactly 3 beats out, count increments at most once.
- miss_cnt_clr asserted in the same cycle as a miss handshake -> arp_miss_count=0. Reset asserted mid-packet -> FIFO empty, M_AXIS_TVALID=0, and a table read of entry 3 returns 0.
- ARP_TTL_REWRITE_EN defined, TTL=0x40, checksum=0xFFFF, ARP hit -> TTL=0x3F, checksum=0x0100.
